// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Function : ID-stage hazard control for the 5-stage pipeline: EX/MEM shadow
//            destinations, operand forwarding selects, load-use and mul/div
//            stalls, taken-branch IF/ID flush and mul/div busy sequencing.
// Options  : HAZARD_FWD_EN - enables ALU operand forwarding; when undefined
//            every EX/MEM RAW dependence stalls instead.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [4:0] IDrs,
    input  logic [4:0] IDrt,
    input  logic       IDuseRs,
    input  logic       IDuseRt,
    input  logic [4:0] IDwn,
    input  logic       IDwreg,
    input  logic       IDm2reg,
    input  logic       IDwmem,
    input  logic       IDisMulDiv,
    input  logic       IDuseHiLo,
    input  logic       IDbranchTaken,
    output logic       pcWe,
    output logic       ifIdWe,
    output logic       ifIdFlush,
    output logic       idExBubble,
    output logic [1:0] IDselectAlua,
    output logic [1:0] IDselectAlub,
    output logic       IDisStoreHazards,
    output logic       mdStart,
    output logic       mdBusy
);

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_EX   = 2'b01;
    localparam logic [1:0] SEL_MEM  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;
    localparam logic [7:0] MD_LOAD  = 8'(MD_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } md_state_t;

    logic [4:0] ex_wn;
    logic       ex_wreg;
    logic       ex_m2reg;
    logic [4:0] mem_wn;
    logic       mem_wreg;
    logic       mem_m2reg;

    logic       ex_hit_rs;
    logic       ex_hit_rt;
    logic       mem_hit_rs;
    logic       mem_hit_rt;

    logic       lu_stall;
    logic       md_stall;
    logic       stall;

    md_state_t  state;
    md_state_t  state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic       md_start_next;

    // r0 is hard-wired zero, so a write to it can never create a dependence
    function automatic logic stage_hit(
        input logic       use_src,
        input logic [4:0] src,
        input logic       wreg,
        input logic [4:0] wn
    );
        return use_src && wreg && (wn == src) && (src != 5'd0);
    endfunction

    assign ex_hit_rs  = stage_hit(IDuseRs, IDrs, ex_wreg,  ex_wn);
    assign ex_hit_rt  = stage_hit(IDuseRt, IDrt, ex_wreg,  ex_wn);
    assign mem_hit_rs = stage_hit(IDuseRs, IDrs, mem_wreg, mem_wn);
    assign mem_hit_rt = stage_hit(IDuseRt, IDrt, mem_wreg, mem_wn);

`ifdef HAZARD_FWD_EN
    // Youngest producer wins; a load still in EX cannot forward and stalls
    function automatic logic [1:0] fwd_sel(
        input logic ex_hit,
        input logic ex_load,
        input logic mem_hit,
        input logic mem_load
    );
        if (ex_hit && !ex_load)
            return SEL_EX;
        if (mem_hit)
            return mem_load ? SEL_LOAD : SEL_MEM;
        return SEL_RF;
    endfunction

    assign lu_stall         = (ex_hit_rs || ex_hit_rt) && ex_m2reg;
    assign IDselectAlua     = fwd_sel(ex_hit_rs, ex_m2reg, mem_hit_rs, mem_m2reg);
    assign IDselectAlub     = fwd_sel(ex_hit_rt, ex_m2reg, mem_hit_rt, mem_m2reg);
    assign IDisStoreHazards = IDwmem && (IDselectAlub != SEL_RF);
`else
    logic unused_fwd;

    // No bypass network: wait until the producer reaches WB
    assign lu_stall         = ex_hit_rs || ex_hit_rt || mem_hit_rs || mem_hit_rt;
    assign IDselectAlua     = SEL_RF;
    assign IDselectAlub     = SEL_RF;
    assign IDisStoreHazards = 1'b0;
    assign unused_fwd       = ^{IDwmem, mem_m2reg, SEL_EX, SEL_MEM, SEL_LOAD};
`endif

    assign md_stall   = mdBusy && (IDisMulDiv || IDuseHiLo);
    assign stall      = lu_stall || md_stall;

    assign pcWe       = !stall;
    assign ifIdWe     = !stall;
    assign idExBubble = stall;
    assign ifIdFlush  = IDbranchTaken && !stall;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ex_wn     <= 5'd0;
            ex_wreg   <= 1'b0;
            ex_m2reg  <= 1'b0;
            mem_wn    <= 5'd0;
            mem_wreg  <= 1'b0;
            mem_m2reg <= 1'b0;
        end else begin
            if (idExBubble) begin
                ex_wn    <= 5'd0;
                ex_wreg  <= 1'b0;
                ex_m2reg <= 1'b0;
            end else begin
                ex_wn    <= IDwn;
                ex_wreg  <= IDwreg;
                ex_m2reg <= IDm2reg;
            end
            mem_wn    <= ex_wn;
            mem_wreg  <= ex_wreg;
            mem_m2reg <= ex_m2reg;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= ST_RUN;
            cnt     <= 8'd0;
            mdStart <= 1'b0;
            mdBusy  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            mdStart <= md_start_next;
            mdBusy  <= (state_next == ST_MD_BUSY);
        end
    end

    // cnt counts the remaining busy cycles after the current one
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        md_start_next = 1'b0;
        case (state)
            ST_RUN: begin
                if (IDisMulDiv && !stall) begin
                    state_next    = ST_MD_BUSY;
                    cnt_next      = MD_LOAD;
                    md_start_next = 1'b1;
                end
            end
            ST_MD_BUSY: begin
                if (cnt == 8'd0)
                    state_next = ST_RUN;
                else
                    cnt_next = cnt - 8'd1;
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = 8'd0;
            end
        endcase
    end

endmodule
`default_nettype wire
